// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite types for the data-memory responder and the CPU-side
// initiator: response codes, write-channel FSM states and per-channel
// payload structs.
package axi_lite_pkg;

  localparam int AXIL_ADDR_W = 32;
  localparam int AXIL_DATA_W = 32;
  localparam int AXIL_STRB_W = AXIL_DATA_W / 8;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } axi_resp_e;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_HAVE_AW,
    WR_HAVE_W,
    WR_RESP
  } axil_wr_state_e;

  typedef struct packed {
    logic [AXIL_ADDR_W-1:0] addr;
  } axil_aw_t;

  typedef struct packed {
    logic [AXIL_DATA_W-1:0] data;
    logic [AXIL_STRB_W-1:0] strb;
  } axil_w_t;

  typedef struct packed {
    logic [AXIL_ADDR_W-1:0] addr;
  } axil_ar_t;

  typedef struct packed {
    logic [AXIL_DATA_W-1:0] data;
    axi_resp_e              resp;
  } axil_r_t;

  typedef struct packed {
    axi_resp_e resp;
  } axil_b_t;

endpackage

// File: rtl/dmem_word_ram.sv
// Word-wide data memory array.
//   clk           : rising-edge clock
//   we/wstrb      : write enable and per-byte lane enables
//   waddr/wdata   : write word index and data
//   re/raddr      : read enable and word index
//   rdata         : registered read data, updated only when re is high
// A read and write to the same word in one cycle returns the old contents.
// The array and the output register are not reset.
module dmem_word_ram #(
  parameter int DEPTH_WORDS = 4096,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [3:0]       wstrb,
  input  logic [IDX_W-1:0] waddr,
  input  logic [31:0]      wdata,
  input  logic             re,
  input  logic [IDX_W-1:0] raddr,
  output logic [31:0]      rdata
);

  logic [3:0][7:0] mem [DEPTH_WORDS];

  // Both ports in one process with non-blocking updates: the read samples
  // the pre-write word on a collision.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) mem[waddr][b] <= wdata[8*b +: 8];
      end
    end
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/dmem_axil_slave.sv
// AXI4-Lite responder holding the CPU data memory.
//   clk, rst_n            : clock, synchronous active-low reset
//   s_aw*, s_w*, s_b*     : write address / data / response channels
//   s_ar*, s_r*           : read address / data channels
// Writes commit once both address and data are available (held or firing);
// reads have a fixed one-cycle latency. Out-of-range accesses answer SLVERR
// without touching the array and return zero read data.
module dmem_axil_slave
  import axi_lite_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DEPTH_WORDS = 4096,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h0001_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] s_awaddr,
  input  logic                  s_awvalid,
  output logic                  s_awready,
  input  logic [31:0]           s_wdata,
  input  logic [3:0]            s_wstrb,
  input  logic                  s_wvalid,
  output logic                  s_wready,
  output logic [1:0]            s_bresp,
  output logic                  s_bvalid,
  input  logic                  s_bready,
  input  logic [ADDR_WIDTH-1:0] s_araddr,
  input  logic                  s_arvalid,
  output logic                  s_arready,
  output logic [31:0]           s_rdata,
  output logic [1:0]            s_rresp,
  output logic                  s_rvalid,
  input  logic                  s_rready
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  // One extra bit so BASE + size cannot wrap at the top of the address space.
  localparam logic [ADDR_WIDTH:0] LIMIT =
    {1'b0, BASE_ADDR} + (ADDR_WIDTH+1)'(DEPTH_WORDS * 4);

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return ({1'b0, a} >= {1'b0, BASE_ADDR}) && ({1'b0, a} < LIMIT);
  endfunction

  // addr[1:0] is dropped; byte placement comes from wstrb alone.
  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] off;
    off = a - BASE_ADDR;
    return IDX_W'(off >> 2);
  endfunction

  // ---------------- write path ----------------
  axil_wr_state_e        state;
  logic                  rdy_en;     // holds readies low for one cycle after reset
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  axil_w_t               w_q;
  axil_b_t               b_q;
  logic                  bvalid_q;

  logic                  aw_held, w_held, aw_fire, w_fire, commit, cm_ok;
  logic [ADDR_WIDTH-1:0] cm_addr;
  axil_w_t               cm_w;

  assign aw_held   = (state == WR_HAVE_AW);
  assign w_held    = (state == WR_HAVE_W);
  assign s_awready = rdy_en && !aw_held && !bvalid_q;
  assign s_wready  = rdy_en && !w_held  && !bvalid_q;
  assign aw_fire   = s_awvalid && s_awready;
  assign w_fire    = s_wvalid  && s_wready;
  assign commit    = (aw_held || aw_fire) && (w_held || w_fire);
  assign cm_addr   = aw_held ? aw_addr_q : s_awaddr;
  assign cm_w      = w_held ? w_q : axil_w_t'{data: s_wdata, strb: s_wstrb};
  assign cm_ok     = in_range(cm_addr);
  assign s_bvalid  = bvalid_q;
  assign s_bresp   = b_q.resp;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= WR_IDLE;
      rdy_en    <= 1'b0;
      bvalid_q  <= 1'b0;
      b_q       <= '{resp: OKAY};
      aw_addr_q <= '0;
      w_q       <= '0;
    end else begin
      rdy_en <= 1'b1;
      if (aw_fire) aw_addr_q <= s_awaddr;
      if (w_fire)  w_q       <= axil_w_t'{data: s_wdata, strb: s_wstrb};
      case (state)
        WR_IDLE: begin
          if (commit)       state <= WR_RESP;
          else if (aw_fire) state <= WR_HAVE_AW;
          else if (w_fire)  state <= WR_HAVE_W;
        end
        WR_HAVE_AW, WR_HAVE_W: if (commit) state <= WR_RESP;
        WR_RESP: begin
          if (s_bready) begin
            state    <= WR_IDLE;
            bvalid_q <= 1'b0;
          end
        end
        default: state <= WR_IDLE;
      endcase
      if (commit) begin
        bvalid_q <= 1'b1;
        b_q      <= '{resp: cm_ok ? OKAY : SLVERR};
      end
    end
  end

  // ---------------- read path ----------------
  logic      rvalid_q, ar_fire, rd_ok;
  axi_resp_e rresp_q;
  logic [31:0] ram_q;

  assign s_arready = rdy_en && (!rvalid_q || s_rready);
  assign ar_fire   = s_arvalid && s_arready;
  assign rd_ok     = in_range(s_araddr);
  assign s_rvalid  = rvalid_q;
  assign s_rresp   = rresp_q;
  // RAM output register is not reset; gate it so idle/error beats read 0.
  assign s_rdata   = (rvalid_q && rresp_q == OKAY) ? ram_q : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rvalid_q <= 1'b0;
      rresp_q  <= OKAY;
    end else if (ar_fire) begin
      rvalid_q <= 1'b1;
      rresp_q  <= rd_ok ? OKAY : SLVERR;
    end else if (s_rready) begin
      rvalid_q <= 1'b0;
    end
  end

  dmem_word_ram #(.DEPTH_WORDS(DEPTH_WORDS), .IDX_W(IDX_W)) u_ram (
    .clk   (clk),
    .we    (commit && cm_ok && rst_n),
    .wstrb (cm_w.strb),
    .waddr (word_idx(cm_addr)),
    .wdata (cm_w.data),
    .re    (ar_fire && rd_ok),
    .raddr (word_idx(s_araddr)),
    .rdata (ram_q)
  );

endmodule

// File: tb/tb_dmem_axil_slave.sv
module tb_dmem_axil_slave;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata;
  logic [3:0]  s_wstrb;
  logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic        s_arvalid, s_arready, s_rvalid, s_rready;
  logic [1:0]  s_bresp, s_rresp;

  int ncmp = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  dmem_axil_slave #(.ADDR_WIDTH(32), .DEPTH_WORDS(4096), .BASE_ADDR(32'h0001_0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready)
  );

  // Stimulus helpers: bounded, report a timeout flag to the caller.
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] resp, output bit to);
    bit aw_d, w_d;
    aw_d = 0; w_d = 0; to = 1; resp = 2'b11;
    @(posedge clk); #1;
    s_awaddr = a; s_awvalid = 1; s_wdata = d; s_wstrb = s; s_wvalid = 1; s_bready = 1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (s_bvalid && aw_d && w_d) begin resp = s_bresp; to = 0; break; end
      if (s_awvalid && s_awready) aw_d = 1;
      if (s_wvalid && s_wready) w_d = 1;
      @(posedge clk); #1;
      if (aw_d) s_awvalid = 0;
      if (w_d) s_wvalid = 0;
    end
    @(posedge clk); #1;
    s_bready = 0; s_awvalid = 0; s_wvalid = 0;
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] d,
                         output logic [1:0] resp, output bit to);
    bit ar_d;
    ar_d = 0; to = 1; d = '0; resp = 2'b11;
    @(posedge clk); #1;
    s_araddr = a; s_arvalid = 1; s_rready = 1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (s_rvalid && ar_d) begin d = s_rdata; resp = s_rresp; to = 0; break; end
      if (s_arvalid && s_arready) ar_d = 1;
      @(posedge clk); #1;
      if (ar_d) s_arvalid = 0;
    end
    @(posedge clk); #1;
    s_rready = 0; s_arvalid = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    s_awaddr = '0; s_awvalid = 0; s_wdata = '0; s_wstrb = '0; s_wvalid = 0; s_bready = 0;
    s_araddr = '0; s_arvalid = 0; s_rready = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    ncmp++;
    if ({s_awready, s_wready, s_bvalid, s_bresp, s_arready, s_rvalid, s_rresp, s_rdata} !== '0) begin
      nerr++; $display("FAIL reset_outputs: got aw%b w%b b%b ar%b r%b rdata=%h, want all 0",
                       s_awready, s_wready, s_bvalid, s_arready, s_rvalid, s_rdata);
    end
    @(posedge clk); #1 rst_n = 1;
    @(negedge clk);
    ncmp++;
    if ({s_awready, s_wready, s_bvalid, s_bresp, s_arready, s_rvalid, s_rresp, s_rdata} !== '0) begin
      nerr++; $display("FAIL first_cycle_outputs: got aw%b w%b ar%b, want 0", s_awready, s_wready, s_arready);
    end
    @(negedge clk);
    ncmp++;
    if ({s_awready, s_wready, s_arready} !== 3'b111) begin
      nerr++; $display("FAIL readies_second_cycle: got %b, want 111", {s_awready, s_wready, s_arready});
    end
  endtask

  task automatic test_single_write();
    @(posedge clk); #1;
    s_awaddr = 32'h0001_0010; s_awvalid = 1; s_wdata = 32'hDEAD_BEEF; s_wstrb = 4'hF; s_wvalid = 1; s_bready = 0;
    @(negedge clk);
    ncmp++;
    if ({s_awready, s_wready, s_bvalid} !== 3'b110) begin
      nerr++; $display("FAIL single_pre_commit: got aw/w/b=%b, want 110", {s_awready, s_wready, s_bvalid});
    end
    @(posedge clk); #1;
    s_awvalid = 0; s_wvalid = 0;
    @(negedge clk);
    ncmp++;
    if ({s_bvalid, s_bresp, s_awready, s_wready} !== 5'b10000) begin
      nerr++; $display("FAIL single_bvalid: got b=%b resp=%b aw=%b w=%b, want b=1 resp=00 readies 0",
                       s_bvalid, s_bresp, s_awready, s_wready);
    end
    @(posedge clk); #1;            // bready still low: bvalid must hold
    @(negedge clk);
    ncmp++;
    if (s_bvalid !== 1'b1) begin nerr++; $display("FAIL bvalid_hold: got %b, want 1", s_bvalid); end
    s_bready = 1;
    @(posedge clk); #1 s_bready = 0;
    @(negedge clk);
    ncmp++;
    if (s_bvalid !== 1'b0) begin nerr++; $display("FAIL bvalid_drop: got %b, want 0", s_bvalid); end
    @(posedge clk); #1;
    s_araddr = 32'h0001_0010; s_arvalid = 1; s_rready = 0;
    @(posedge clk); #1 s_arvalid = 0;
    @(negedge clk);
    ncmp++;
    if ({s_rvalid, s_rresp, s_rdata} !== {1'b1, 2'b00, 32'hDEAD_BEEF}) begin
      nerr++; $display("FAIL single_readback: got v=%b resp=%b data=%h, want 1/00/deadbeef", s_rvalid, s_rresp, s_rdata);
    end
    s_rready = 1;
    @(posedge clk); #1 s_rready = 0;
  endtask

  task automatic test_strobe();
    logic [31:0] d; logic [1:0] r; bit to;
    do_write(32'h0001_0010, 32'h0000_AA00, 4'b0010, r, to);
    ncmp++;
    if (to || r !== 2'b00) begin nerr++; $display("FAIL strobe_bresp: got %b timeout=%0d, want 00", r, to); end
    do_read(32'h0001_0010, d, r, to);
    ncmp++;
    if (to || d !== 32'hDEAD_AAEF) begin nerr++; $display("FAIL strobe_data: got %h, want deadaaef", d); end
    do_write(32'h0001_0010, 32'hFFFF_FFFF, 4'b0000, r, to);
    ncmp++;
    if (to || r !== 2'b00) begin nerr++; $display("FAIL zero_strb_bresp: got %b timeout=%0d, want 00", r, to); end
    do_read(32'h0001_0010, d, r, to);
    ncmp++;
    if (to || d !== 32'hDEAD_AAEF) begin nerr++; $display("FAIL zero_strb_data: got %h, want deadaaef", d); end
  endtask

  task automatic test_out_of_order();
    logic [31:0] d; logic [1:0] r; bit to;
    @(posedge clk); #1;
    s_wdata = 32'h1234_5678; s_wstrb = 4'hF; s_wvalid = 1; s_bready = 0;
    @(posedge clk); #1 s_wvalid = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      ncmp++;
      if ({s_bvalid, s_wready, s_awready} !== 3'b001) begin
        nerr++; $display("FAIL ooo_wait%0d: got b/w/aw=%b, want 001", k, {s_bvalid, s_wready, s_awready});
      end
      @(posedge clk);
    end
    #1 s_awaddr = 32'h0001_0020; s_awvalid = 1;
    @(posedge clk); #1 s_awvalid = 0;
    @(negedge clk);
    ncmp++;
    if ({s_bvalid, s_bresp} !== 3'b100) begin
      nerr++; $display("FAIL ooo_bvalid: got b=%b resp=%b, want 1/00", s_bvalid, s_bresp);
    end
    s_bready = 1;
    @(posedge clk); #1 s_bready = 0;
    do_read(32'h0001_0020, d, r, to);
    ncmp++;
    if (to || d !== 32'h1234_5678) begin nerr++; $display("FAIL ooo_data: got %h, want 12345678", d); end
  endtask

  task automatic test_out_of_range();
    logic [31:0] d; logic [1:0] r; bit to;
    // 0x0000_0004 would alias word 1 if the range check were skipped.
    do_write(32'h0001_0004, 32'hCAFE_F00D, 4'hF, r, to);
    do_write(32'h0000_0004, 32'hFFFF_FFFF, 4'hF, r, to);
    ncmp++;
    if (to || r !== 2'b10) begin nerr++; $display("FAIL oor_bresp: got %b timeout=%0d, want 10", r, to); end
    do_read(32'h0001_0004, d, r, to);
    ncmp++;
    if (to || d !== 32'hCAFE_F00D) begin nerr++; $display("FAIL oor_unchanged: got %h, want cafef00d", d); end
    do_read(32'h0001_4000, d, r, to);
    ncmp++;
    if (to || r !== 2'b10 || d !== 32'h0) begin
      nerr++; $display("FAIL oor_read_top: got resp=%b data=%h, want 10/0", r, d);
    end
    do_read(32'h0000_FFFC, d, r, to);
    ncmp++;
    if (to || r !== 2'b10 || d !== 32'h0) begin
      nerr++; $display("FAIL oor_read_below: got resp=%b data=%h, want 10/0", r, d);
    end
    do_read(32'h0001_3FFC, d, r, to);
    ncmp++;
    if (to || r !== 2'b00) begin nerr++; $display("FAIL last_word_resp: got %b, want 00", r); end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp [4];
    logic [31:0] d; logic [1:0] r; bit to;
    int i, k, stall, cyc;
    bit seen;
    exp[0] = 32'hA0A0_0000; exp[1] = 32'hA1A1_1111; exp[2] = 32'hA2A2_2222; exp[3] = 32'hA3A3_3333;
    for (int n = 0; n < 4; n++) do_write(32'h0001_0100 + 32'(n * 4), exp[n], 4'hF, r, to);
    i = 0; k = 0; stall = 0; cyc = 0; seen = 0;
    for (int c = 0; c < 30 && k < 4; c++) begin
      @(posedge clk); #1;
      cyc++;
      s_arvalid = (i < 4);
      s_araddr  = 32'h0001_0100 + 32'(i * 4);
      if (s_rvalid && !seen) seen = 1;
      s_rready = !(seen && stall < 2);
      if (!s_rready) stall++;
      @(negedge clk);
      if (!s_rready) begin
        ncmp++;
        if (s_rdata !== exp[0] || s_arready !== 1'b0 || s_rvalid !== 1'b1) begin
          nerr++; $display("FAIL bp_stall: got rdata=%h arready=%b rvalid=%b, want %h/0/1",
                           s_rdata, s_arready, s_rvalid, exp[0]);
        end
      end
      if (s_rvalid && s_rready) begin
        ncmp++;
        if (s_rdata !== exp[k]) begin nerr++; $display("FAIL bp_order%0d: got %h, want %h", k, s_rdata, exp[k]); end
        k++;
      end
      if (s_arvalid && s_arready) i++;
    end
    ncmp++;
    if (k != 4 || cyc != 7) begin
      nerr++; $display("FAIL bp_throughput: got %0d reads in %0d cycles, want 4 in 7", k, cyc);
    end
    @(posedge clk); #1 s_arvalid = 0; s_rready = 0;
  endtask

  task automatic test_collision();
    logic [1:0] r; bit to;
    do_write(32'h0001_0200, 32'h1111_1111, 4'hF, r, to);
    @(posedge clk); #1;
    s_awaddr = 32'h0001_0200; s_awvalid = 1; s_wdata = 32'h2222_2222; s_wstrb = 4'hF; s_wvalid = 1;
    s_araddr = 32'h0001_0200; s_arvalid = 1; s_rready = 1; s_bready = 1;
    @(posedge clk); #1 s_awvalid = 0; s_wvalid = 0;   // AR stays up for a second read
    @(negedge clk);
    ncmp++;
    if ({s_rvalid, s_rdata, s_bvalid} !== {1'b1, 32'h1111_1111, 1'b1}) begin
      nerr++; $display("FAIL collision_old: got rv=%b data=%h bv=%b, want 1/11111111/1", s_rvalid, s_rdata, s_bvalid);
    end
    @(posedge clk); #1 s_arvalid = 0;
    @(negedge clk);
    ncmp++;
    if ({s_rvalid, s_rdata} !== {1'b1, 32'h2222_2222}) begin
      nerr++; $display("FAIL collision_new: got rv=%b data=%h, want 1/22222222", s_rvalid, s_rdata);
    end
    @(posedge clk); #1 s_rready = 0; s_bready = 0;
  endtask

  task automatic test_mid_reset();
    logic [31:0] d; logic [1:0] r; bit to;
    @(posedge clk); #1;
    s_awaddr = 32'h0001_0300; s_awvalid = 1; s_wdata = 32'h5A5A_0F0F; s_wstrb = 4'hF; s_wvalid = 1; s_bready = 0;
    @(posedge clk); #1 s_awvalid = 0; s_wvalid = 0;
    @(negedge clk);
    ncmp++;
    if (s_bvalid !== 1'b1) begin nerr++; $display("FAIL midrst_pre: got bvalid=%b, want 1", s_bvalid); end
    rst_n = 0;
    @(negedge clk);
    ncmp++;
    if ({s_bvalid, s_awready, s_wready, s_arready} !== 4'b0000) begin
      nerr++; $display("FAIL midrst_clear: got b/aw/w/ar=%b, want 0000", {s_bvalid, s_awready, s_wready, s_arready});
    end
    @(posedge clk); #1 rst_n = 1;
    repeat (2) @(posedge clk);
    do_read(32'h0001_0300, d, r, to);
    ncmp++;
    if (to || d !== 32'h5A5A_0F0F) begin nerr++; $display("FAIL midrst_kept: got %h, want 5a5a0f0f", d); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_strobe();
    test_out_of_order();
    test_out_of_range();
    test_backpressure();
    test_collision();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
